// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_feeder
// Description : Walks an IMG_H x IMG_W image held in a 3-port synchronous-read
//               pixel memory, fetching one 3-pixel column per cycle (rows r,
//               r+1, r+2) and pushing it into the downstream 3x3 line buffer.
//               Flags the cycles in which the line buffer holds a complete
//               3x3 window and reports its top-left coordinate.
// Ports       : clk, rst (async, active-high)
//               start        - begin a frame (sampled in IDLE only)
//               stall        - back-pressure, blocks issue of new columns
//               mem_rd_en    - read strobe shared by the three memory ports
//               mem_addr_rN  - row-major addresses for rows r, r+1, r+2
//               mem_data_rN  - read data, valid the cycle after mem_rd_en
//               wr_en/shift  - line buffer push strobes (always equal)
//               data_out_rN  - pixels to line buffer data_in_r1..r3
//               window_valid - line buffer holds a complete window
//               win_row/col  - top row / left column of that window
//               busy         - frame in progress
//               done         - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_feeder #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stall,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr_r1,
    output logic [ADDR_W-1:0]          mem_addr_r2,
    output logic [ADDR_W-1:0]          mem_addr_r3,
    input  logic [BIT_DEPTH-1:0]       mem_data_r1,
    input  logic [BIT_DEPTH-1:0]       mem_data_r2,
    input  logic [BIT_DEPTH-1:0]       mem_data_r3,
    output logic                       wr_en,
    output logic                       shift,
    output logic [BIT_DEPTH-1:0]       data_out_r1,
    output logic [BIT_DEPTH-1:0]       data_out_r2,
    output logic [BIT_DEPTH-1:0]       data_out_r3,
    output logic                       window_valid,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       busy,
    output logic                       done
);

    localparam int c_ROW_W = $clog2(IMG_H);
    localparam int c_COL_W = $clog2(IMG_W);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW   = c_ROW_W'(IMG_H - 3);
    localparam logic [c_COL_W-1:0] c_LAST_COL   = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_TWO        = c_COL_W'(2);
    localparam logic [ADDR_W-1:0]  c_ROW_STRIDE = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_COL_W-1:0]     r_col;
    logic [ADDR_W-1:0]      r_base;      // r_row * IMG_W, kept incrementally

    // Stage 1: read outstanding at the memory
    logic                   r_v1;
    logic [c_ROW_W-1:0]     r_row1;
    logic [c_COL_W-1:0]     r_col1;
    // Stage 2: column registered, being pushed into the line buffer
    logic                   r_wr_en;
    logic [c_ROW_W-1:0]     r_row2;
    logic [c_COL_W-1:0]     r_col2;
    logic [BIT_DEPTH-1:0]   r_d1;
    logic [BIT_DEPTH-1:0]   r_d2;
    logic [BIT_DEPTH-1:0]   r_d3;
    // Stage 3: window report
    logic                   r_win_valid;
    logic [c_ROW_W-1:0]     r_win_row;
    logic [c_COL_W-1:0]     r_win_col;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_issue;
    logic [ADDR_W-1:0]      w_addr1;
    logic [ADDR_W-1:0]      w_addr2;
    logic [ADDR_W-1:0]      w_addr3;

    assign w_issue = (r_state == ST_FETCH) && !stall;
    assign w_addr1 = r_base + ADDR_W'(r_col);
    assign w_addr2 = w_addr1 + c_ROW_STRIDE;
    assign w_addr3 = w_addr2 + c_ROW_STRIDE;

    // Addresses are forced to zero when no read is issued so idle outputs are quiet.
    assign mem_rd_en    = w_issue;
    assign mem_addr_r1  = w_issue ? w_addr1 : '0;
    assign mem_addr_r2  = w_issue ? w_addr2 : '0;
    assign mem_addr_r3  = w_issue ? w_addr3 : '0;

    assign wr_en        = r_wr_en;
    assign shift        = r_wr_en;
    assign data_out_r1  = r_d1;
    assign data_out_r2  = r_d2;
    assign data_out_r3  = r_d3;
    assign window_valid = r_win_valid;
    assign win_row      = r_win_row;
    assign win_col      = r_win_col;
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_base      <= '0;
            r_v1        <= 1'b0;
            r_row1      <= '0;
            r_col1      <= '0;
            r_wr_en     <= 1'b0;
            r_row2      <= '0;
            r_col2      <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_d3        <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Fetch pipeline: issue -> memory -> registered push -> window flag.
            // It runs independently of stall so an issued column always lands.
            r_v1 <= w_issue;
            if (w_issue) begin
                r_row1 <= r_row;
                r_col1 <= r_col;
            end

            r_wr_en <= r_v1;
            if (r_v1) begin
                r_d1   <= mem_data_r1;
                r_d2   <= mem_data_r2;
                r_d3   <= mem_data_r3;
                r_row2 <= r_row1;
                r_col2 <= r_col1;
            end

            // Column index restarts per band, so the first two pushes of a
            // band (which sit beside stale columns) never raise a window.
            r_win_valid <= r_wr_en && (r_col2 >= c_TWO);
            if (r_wr_en && (r_col2 >= c_TWO)) begin
                r_win_row <= r_row2;
                r_win_col <= r_col2 - c_TWO;
            end

            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_base  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        if (r_col == c_LAST_COL) begin
                            r_col <= '0;
                            if (r_row == c_LAST_ROW) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_row  <= r_row + 1'b1;
                                r_base <= r_base + c_ROW_STRIDE;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Once the last read has left stage 1, the final push is
                    // in stage 2 and its window flag lands together with done.
                    if (!r_v1) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
